adc_trigger_responder: RTL

//   Receive-side end of the ADC trigger handshake driven by the transmit output controller
//   (trigger line out, trigger ack in). Synchronises the incoming trigger line and returns
//   a four-phase acknowledge. When armed, it waits a programmed delay and then writes a

---
 rtl/adc_trigger_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/adc_trigger_responder.sv
// adc_trigger_responder: receive-side ADC trigger handshake with delayed sample capture into RAM
//   rxCLK/rxRESET        clock, asynchronous active-high reset
//   irxArm/irxAbort      arm capture from IDLE/DONE; abort to IDLE from any state
//   irxIntClear          clears the sticky interrupt bits (a new set wins)
//   irxRecLength/Delay   record length and trigger-to-capture delay, latched on the accepted trigger
//   irxADCTriggerLine    asynchronous trigger line; orxADCTriggerAck is its four-phase acknowledge
//   irxAdcData/Valid     ADC sample stream
//   orxRamWr*            registered RAM write port
//   orxBusy/orxDone      DELAY or CAPTURE / DONE status
//   orxInterrupt         [0] done [1] missed trigger [2] empty record [3] abort
module adc_trigger_responder #(
   parameter int DATA_W      = 12,
   parameter int ADDR_W      = 14,
   parameter int DELAY_W     = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic               rxCLK,
   input  logic               rxRESET,
   input  logic               irxArm,
   input  logic               irxAbort,
   input  logic               irxIntClear,
   input  logic [ADDR_W-1:0]  irxRecLength,
   input  logic [DELAY_W-1:0] irxRecDelay,
   input  logic               irxADCTriggerLine,
   output logic               orxADCTriggerAck,
   input  logic [DATA_W-1:0]  irxAdcData,
   input  logic               irxAdcValid,
   output logic [ADDR_W-1:0]  orxRamWrAddr,
   output logic [DATA_W-1:0]  orxRamWrData,
   output logic               orxRamWrEn,
   output logic               orxBusy,
   output logic               orxDone,
   output logic [3:0]         orxInterrupt
);
   typedef enum logic [2:0] {IDLE, ARMED, DELAY, CAPTURE, DONE} state_t;
   state_t state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic trig_s, trig_d_q, rise, ack_q, ack_d, we_q, we_d;
   logic [ADDR_W-1:0] len_q, len_d, cnt_q, cnt_d, addr_q, addr_d;
   logic [DELAY_W-1:0] dly_q, dly_d, dcnt_q, dcnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [3:0] int_q, int_d, set;
   assign trig_s = sync_q[SYNC_STAGES-1];
   assign rise   = trig_s & ~trig_d_q;
   // ack rises on a synchronised rising edge and falls once the line is seen low
   assign ack_d  = rise | (ack_q & trig_s);
   assign int_d  = (int_q & ~{4{irxIntClear}}) | set;
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      dly_d   = dly_q;
      dcnt_d  = dcnt_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      set     = {2'b00, rise & (state_q != ARMED), 1'b0};
      if (irxAbort) begin
         state_d = IDLE;
         set[3]  = (state_q == DELAY) || (state_q == CAPTURE);
      end else begin
         case (state_q)
            IDLE, DONE: if (irxArm) begin
               state_d = ARMED;
               cnt_d   = '0;
            end
            ARMED: if (rise) begin
               len_d  = irxRecLength;
               dly_d  = irxRecDelay;
               dcnt_d = '0;
               if (irxRecLength == '0) begin
                  state_d = DONE;
                  set[2]  = 1'b1;
                  set[0]  = 1'b1;
               end else begin
                  state_d = (irxRecDelay == '0) ? CAPTURE : DELAY;
               end
            end
            // DELAY lasts exactly dly_q cycles
            DELAY: if (dcnt_q == dly_q - DELAY_W'(1)) state_d = CAPTURE;
                   else dcnt_d = dcnt_q + DELAY_W'(1);
            CAPTURE: if (irxAdcValid) begin
               we_d   = 1'b1;
               addr_d = cnt_q;
               data_d = irxAdcData;
               cnt_d  = cnt_q + ADDR_W'(1);
               if (cnt_q == len_q - ADDR_W'(1)) begin
                  state_d = DONE;
                  set[0]  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge rxCLK or posedge rxRESET) begin
      if (rxRESET) begin
         state_q  <= IDLE;
         sync_q   <= '0;
         trig_d_q <= 1'b0;
         ack_q    <= 1'b0;
         we_q     <= 1'b0;
         len_q    <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         dly_q    <= '0;
         dcnt_q   <= '0;
         data_q   <= '0;
         int_q    <= '0;
      end else begin
         state_q  <= state_d;
         sync_q   <= {sync_q[SYNC_STAGES-2:0], irxADCTriggerLine};
         trig_d_q <= trig_s;
         ack_q    <= ack_d;
         we_q     <= we_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         dly_q    <= dly_d;
         dcnt_q   <= dcnt_d;
         data_q   <= data_d;
         int_q    <= int_d;
      end
   end
   assign orxADCTriggerAck = ack_q;
   // abort suppresses a pending write in the very cycle it is asserted
   assign orxRamWrEn       = we_q & ~irxAbort;
   assign orxRamWrAddr     = addr_q;
   assign orxRamWrData     = data_q;
   assign orxBusy          = (state_q == DELAY) || (state_q == CAPTURE);
   assign orxDone          = state_q == DONE;
   assign orxInterrupt     = int_q;
endmodule
